// File: rtl/ex.sv
// EX pipeline stage: input register, one-hot ALU, HI/LO unit with a
// single-cycle multiplier and a 32-iteration restoring divider, data-SRAM
// request generation and the forwarding bus back to decode.
module ex (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // ---------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------
  logic [158:0] r_id_ex;

  // Capture from decode; a stalled-behind-a-moving-stage slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_id_ex <= '0;
    end else if (stall[2] && !stall[3]) begin
      r_id_ex <= '0;
    end else if (!stall[2]) begin
      r_id_ex <= id_to_ex_bus;
    end
  end

  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2;
  logic        w_ram_en;
  logic [3:0]  w_ram_wen;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic        w_sel_rf_res;
  logic [31:0] w_data1;
  logic [31:0] w_data2;

  assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
          w_rf_we, w_rf_waddr, w_sel_rf_res, w_data1, w_data2} = r_id_ex;

  // Instruction fields the stage does not look at
  logic w_unused_bits;
  assign w_unused_bits = ^{stall[5:4], stall[1:0], w_inst[25:16]};

  // ---------------------------------------------------------------------
  // Operand selection and ALU
  // ---------------------------------------------------------------------
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;
  logic [31:0] w_src1;
  logic [31:0] w_src2;

  assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
  assign w_imm_zext = {16'd0, w_inst[15:0]};

  assign w_src1 = ({32{w_sel_src1[0]}} & w_data1)
                | ({32{w_sel_src1[1]}} & w_pc)
                | ({32{w_sel_src1[2]}} & {27'd0, w_inst[10:6]});

  assign w_src2 = ({32{w_sel_src2[0]}} & w_data2)
                | ({32{w_sel_src2[1]}} & w_imm_sext)
                | ({32{w_sel_src2[2]}} & 32'd8)
                | ({32{w_sel_src2[3]}} & w_imm_zext);

  // One result lane per alu_op bit (bit 11 = add ... bit 0 = lui)
  logic [31:0] w_lane        [12];
  logic [31:0] w_lane_masked [12];

  assign w_lane[11] = w_src1 + w_src2;
  assign w_lane[10] = w_src1 - w_src2;
  assign w_lane[9]  = {31'd0, ($signed(w_src1) < $signed(w_src2))};
  assign w_lane[8]  = {31'd0, (w_src1 < w_src2)};
  assign w_lane[7]  = w_src1 & w_src2;
  assign w_lane[6]  = ~(w_src1 | w_src2);
  assign w_lane[5]  = w_src1 | w_src2;
  assign w_lane[4]  = w_src1 ^ w_src2;
  assign w_lane[3]  = w_src2 << w_src1[4:0];
  assign w_lane[2]  = w_src2 >> w_src1[4:0];
  assign w_lane[1]  = $signed(w_src2) >>> w_src1[4:0];
  assign w_lane[0]  = {w_src2[15:0], 16'd0};

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_lane
      assign w_lane_masked[gi] = {32{w_alu_op[gi]}} & w_lane[gi];
    end
  endgenerate

  logic [31:0] w_alu_res;

  // OR the selected lane(s) together
  always_comb begin
    w_alu_res = '0;
    for (int i = 0; i < 12; i++) begin
      w_alu_res = w_alu_res | w_lane_masked[i];
    end
  end

  // ---------------------------------------------------------------------
  // HI/LO instruction decode
  // ---------------------------------------------------------------------
  logic       w_special;
  logic [5:0] w_funct;
  logic       w_is_mult, w_is_multu, w_is_div, w_is_divu;
  logic       w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic       w_is_div_op;

  assign w_special   = (w_inst[31:26] == 6'd0);
  assign w_funct     = w_inst[5:0];
  assign w_is_mult   = w_special && (w_funct == FN_MULT);
  assign w_is_multu  = w_special && (w_funct == FN_MULTU);
  assign w_is_div    = w_special && (w_funct == FN_DIV);
  assign w_is_divu   = w_special && (w_funct == FN_DIVU);
  assign w_is_mfhi   = w_special && (w_funct == FN_MFHI);
  assign w_is_mflo   = w_special && (w_funct == FN_MFLO);
  assign w_is_mthi   = w_special && (w_funct == FN_MTHI);
  assign w_is_mtlo   = w_special && (w_funct == FN_MTLO);
  assign w_is_div_op = w_is_div || w_is_divu;

  // Full 64-bit products; operands widened so the multiply is 64x64
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_prod_s = $signed({{32{w_data1[31]}}, w_data1}) * $signed({{32{w_data2[31]}}, w_data2});
  assign w_prod_u = {32'd0, w_data1} * {32'd0, w_data2};

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  div_state_t  r_state;
  div_state_t  w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_div_q;     // dividend shifting out, quotient shifting in
  logic [31:0] r_div_rem;
  logic [31:0] r_div_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        w_div_start;
  logic        w_div_step;
  logic        w_div_commit;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;

  assign w_abs1 = (w_is_div && w_data1[31]) ? (~w_data1 + 32'd1) : w_data1;
  assign w_abs2 = (w_is_div && w_data2[31]) ? (~w_data2 + 32'd1) : w_data2;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", which naturally yields q=all ones, rem=dividend.
  logic [32:0] w_shift;
  logic        w_fit;
  logic [31:0] w_rem_next;
  logic [31:0] w_q_next;

  assign w_shift    = {r_div_rem, r_div_q[31]};
  assign w_fit      = (w_shift >= {1'b0, r_div_dvs});
  assign w_rem_next = w_fit ? (w_shift[31:0] - r_div_dvs) : w_shift[31:0];
  assign w_q_next   = {r_div_q[30:0], w_fit};

  logic [31:0] w_quot;
  logic [31:0] w_rmd;

  assign w_quot = r_neg_q ? (~r_div_q + 32'd1) : r_div_q;
  assign w_rmd  = r_neg_r ? (~r_div_rem + 32'd1) : r_div_rem;

  // Divider state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Divider next state and control strobes
  always_comb begin
    w_state_next    = r_state;
    w_div_start     = 1'b0;
    w_div_step      = 1'b0;
    w_div_commit    = 1'b0;
    stallreq_for_ex = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_div_op) begin
          stallreq_for_ex = 1'b1;
          w_div_start     = 1'b1;
          w_state_next    = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq_for_ex = 1'b1;
        w_div_step      = 1'b1;
        if (r_cnt == 5'd31) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall[2]) begin
          w_div_commit = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Divider datapath: latch magnitudes and signs, then iterate
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_div_q   <= '0;
      r_div_rem <= '0;
      r_div_dvs <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (w_div_start) begin
      r_cnt     <= '0;
      r_div_q   <= w_abs1;
      r_div_rem <= '0;
      r_div_dvs <= w_abs2;
      r_neg_q   <= w_is_div && (w_data1[31] ^ w_data2[31]);
      r_neg_r   <= w_is_div && w_data1[31];
    end else if (w_div_step) begin
      r_cnt     <= r_cnt + 5'd1;
      r_div_q   <= w_q_next;
      r_div_rem <= w_rem_next;
    end
  end

  // ---------------------------------------------------------------------
  // HI/LO registers
  // ---------------------------------------------------------------------
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Divide results take priority; the others write only as the instruction leaves EX
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_div_commit) begin
      r_hi <= w_rmd;
      r_lo <= w_quot;
    end else if (!stall[2] && (r_state == S_IDLE)) begin
      if (w_is_mult) begin
        r_hi <= w_prod_s[63:32];
        r_lo <= w_prod_s[31:0];
      end else if (w_is_multu) begin
        r_hi <= w_prod_u[63:32];
        r_lo <= w_prod_u[31:0];
      end else if (w_is_mthi) begin
        r_hi <= w_data1;
      end else if (w_is_mtlo) begin
        r_lo <= w_data1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic        w_bubble;
  logic [31:0] w_ex_result;
  logic        w_fwd_we;

  assign w_bubble    = (w_alu_op == 12'd0) && !w_rf_we;
  assign w_ex_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu_res);
  assign w_fwd_we    = w_rf_we && (r_state == S_IDLE);

  assign ex_to_mem_bus   = w_bubble ? '0 : {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res,
                                            w_rf_we, w_rf_waddr, w_ex_result};
  assign ex_to_rf_bus    = w_bubble ? '0 : {w_fwd_we, w_rf_waddr, w_ex_result};
  assign data_sram_en    = w_bubble ? 1'b0 : w_ram_en;
  assign data_sram_wen   = w_bubble ? 4'd0 : w_ram_wen;
  assign data_sram_addr  = w_bubble ? 32'd0 : (w_data1 + w_imm_sext);
  assign data_sram_wdata = w_bubble ? 32'd0 : w_data2;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the EX stage: table of ALU/SRAM vectors plus
// hand-written HI/LO, divider, reset and stall sequences.
module tb_ex;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   tb_stall;
  logic [5:0]   w_stall;
  logic [158:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  always #5 clk = ~clk;

  // Stall controller model: an EX stall request freezes IF..EX and bubbles MEM
  assign w_stall = stallreq_for_ex ? 6'b001111 : tb_stall;

  ex dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (w_stall),
    .id_to_ex_bus   (id_bus),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .ex_to_rf_bus   (ex_to_rf_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex)
  );

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR = 12'h020, OP_XOR = 12'h010;
  localparam logic [11:0] OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;
  localparam logic [2:0]  S1_D1 = 3'd1, S1_PC = 3'd2, S1_SA = 3'd4;
  localparam logic [3:0]  S2_D2 = 4'd1, S2_IMM = 4'd2, S2_8 = 4'd4, S2_ZIMM = 4'd8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        ren;
    logic [3:0]  rwen;
    logic        we;
    logic [4:0]  wa;
    logic        srr;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] res;
    logic [31:0] addr;
    logic        bub;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ren,
                                      input logic [3:0] rwen, input logic we,
                                      input logic [4:0] wa, input logic srr,
                                      input logic [31:0] d1, input logic [31:0] d2);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, srr, d1, d2};
  endfunction

  function automatic logic [158:0] hilo_inst(input logic [5:0] fn, input logic we,
                                             input logic [31:0] d1, input logic [31:0] d2);
    return mk(32'h0040_0200, {26'd0, fn}, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, we,
              we ? 5'd3 : 5'd0, 1'b0, d1, d2);
  endfunction

  task automatic addv(input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
                      input logic [2:0] s1, input logic [3:0] s2, input logic ren,
                      input logic [3:0] rwen, input logic we, input logic [4:0] wa,
                      input logic srr, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] res, input logic [31:0] addr, input logic bub);
    vec_t v;
    v.pc = pc; v.inst = inst; v.op = op; v.s1 = s1; v.s2 = s2;
    v.ren = ren; v.rwen = rwen; v.we = we; v.wa = wa; v.srr = srr;
    v.d1 = d1; v.d2 = d2; v.res = res; v.addr = addr; v.bub = bub;
    vecs.push_back(v);
  endtask

  function automatic logic [158:0] vbus(input vec_t v);
    return mk(v.pc, v.inst, v.op, v.s1, v.s2, v.ren, v.rwen, v.we, v.wa, v.srr, v.d1, v.d2);
  endfunction

  function automatic logic [75:0] exp_mem(input vec_t v);
    return v.bub ? 76'd0 : {v.pc, v.ren, v.rwen, v.srr, v.we, v.wa, v.res};
  endfunction

  function automatic logic [37:0] exp_rf(input vec_t v);
    return v.bub ? 38'd0 : {v.we, v.wa, v.res};
  endfunction

  function automatic logic [68:0] exp_sram(input vec_t v);
    return v.bub ? 69'd0 : {v.ren, v.rwen, v.addr, v.d2};
  endfunction

  function automatic logic [68:0] sram_now();
    return {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata};
  endfunction

  // Issue a divide, count the stall cycles, optionally hold in DONE, then read LO and HI
  task automatic do_div(input string nm, input logic [5:0] fn, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input int hold);
    int cyc;
    cyc = 0;
    tb_stall = 6'd0;
    id_bus = hilo_inst(fn, 1'b0, d1, d2);
    tick();
    id_bus = hilo_inst(6'h12, 1'b1, 32'd0, 32'd0);
    while (stallreq_for_ex && cyc < 200) begin
      cyc++;
      tick();
    end
    chk({nm, "_stall_cycles"}, cyc, 33);
    $display("%s: stallreq high for %0d cycles", nm, cyc);
    tb_stall = 6'b001111;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({nm, "_done_hold_stallreq"}, stallreq_for_ex, 1'b0);
    end
    tb_stall = 6'd0;
    tick();
    chk({nm, "_lo"}, ex_to_rf_bus, {1'b1, 5'd3, exp_lo});
    $display("%s: mflo -> %h", nm, ex_to_rf_bus[31:0]);
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    tick();
    chk({nm, "_hi"}, ex_to_rf_bus, {1'b1, 5'd3, exp_hi});
    $display("%s: mfhi -> %h", nm, ex_to_rf_bus[31:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   pc            inst          op       s1     s2       ren rwen   we wa    srr d1            d2            res           addr          bub
    addv(32'h00400000, 32'h2422FFFF, OP_ADD,  S1_D1, S2_IMM,  0, 4'h0, 1, 5'd2, 0, 32'h00000005, 32'h00000000, 32'h00000004, 32'h00000004, 0);
    addv(32'h00400004, 32'h00000000, OP_SUB,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd3, 0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h00000003, 0);
    addv(32'h00400008, 32'h00000000, OP_SLT,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd4, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 0);
    addv(32'h0040000C, 32'h00000000, OP_SLTU, S1_D1, S2_D2,   0, 4'h0, 1, 5'd5, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0);
    addv(32'h00400010, 32'h00000000, OP_AND,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd6, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF0F0F0F0, 0);
    addv(32'h00400014, 32'h00000000, OP_NOR,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd7, 0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0, 0);
    addv(32'h00400018, 32'h00000000, OP_OR,   S1_D1, S2_D2,   0, 4'h0, 1, 5'd8, 0, 32'h12340000, 32'h00005678, 32'h12345678, 32'h12340000, 0);
    addv(32'h0040001C, 32'h00000000, OP_XOR,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd9, 0, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'hFFFF0000, 0);
    addv(32'h00400020, 32'h00000100, OP_SLL,  S1_SA, S2_D2,   0, 4'h0, 1, 5'd10, 0, 32'h00000000, 32'h00000011, 32'h00000110, 32'h00000100, 0);
    addv(32'h00400024, 32'h00000100, OP_SRL,  S1_SA, S2_D2,   0, 4'h0, 1, 5'd11, 0, 32'h00000000, 32'h80000000, 32'h08000000, 32'h00000100, 0);
    addv(32'h00400028, 32'h00000100, OP_SRA,  S1_SA, S2_D2,   0, 4'h0, 1, 5'd12, 0, 32'h00000000, 32'h80000000, 32'hF8000000, 32'h00000100, 0);
    addv(32'h0040002C, 32'h00000000, OP_SLL,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd13, 0, 32'h00000021, 32'h00000003, 32'h00000006, 32'h00000021, 0);
    addv(32'h00400030, 32'h3C011234, OP_LUI,  3'd0,  S2_ZIMM, 0, 4'h0, 1, 5'd1, 0, 32'h00000000, 32'h00000000, 32'h12340000, 32'h00001234, 0);
    addv(32'hBFC00000, 32'h0C000000, OP_ADD,  S1_PC, S2_8,    0, 4'h0, 1, 5'd31, 0, 32'h00000000, 32'h00000000, 32'hBFC00008, 32'h00000000, 0);
    addv(32'h00400038, 32'h8C22FFFC, OP_ADD,  S1_D1, S2_IMM,  1, 4'h0, 1, 5'd2, 1, 32'h00001000, 32'h00000000, 32'h00000FFC, 32'h00000FFC, 0);
    addv(32'h0040003C, 32'hAC220010, OP_ADD,  S1_D1, S2_IMM,  1, 4'hF, 0, 5'd0, 0, 32'h00002000, 32'hDEADBEEF, 32'h00002010, 32'h00002010, 0);
    addv(32'h00400040, 32'h12345678, 12'd0,   S1_D1, S2_D2,   1, 4'hF, 0, 5'd0, 0, 32'h00000011, 32'h00000022, 32'h00000000, 32'h00000000, 1);
    addv(32'h00400044, 32'h00000000, OP_ADD,  S1_D1, S2_D2,   0, 4'h0, 1, 5'd14, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 0);
    addv(32'h00400048, 32'h00008000, OP_ADD,  S1_D1, S2_IMM,  0, 4'h0, 1, 5'd15, 0, 32'h00000000, 32'h00000000, 32'hFFFF8000, 32'hFFFF8000, 0);
    addv(32'h0040004C, 32'h00008000, OP_OR,   S1_D1, S2_ZIMM, 0, 4'h0, 1, 5'd16, 0, 32'h00000000, 32'h00000000, 32'h00008000, 32'hFFFF8000, 0);

    // Reset state: outputs zero even with a live instruction at the input
    rst = 1'b0;
    tb_stall = 6'd0;
    id_bus = vbus(vecs[0]);
    tick();
    tick();
    chk("reset_mem_bus", ex_to_mem_bus, 76'd0);
    chk("reset_rf_bus", ex_to_rf_bus, 38'd0);
    chk("reset_sram", sram_now(), 69'd0);
    chk("reset_stallreq", stallreq_for_ex, 1'b0);
    $display("reset: mem_bus=%h rf_bus=%h stallreq=%b", ex_to_mem_bus, ex_to_rf_bus, stallreq_for_ex);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      id_bus = vbus(vecs[i]);
      tick();
      chk($sformatf("vec%0d_mem_bus", i), ex_to_mem_bus, exp_mem(vecs[i]));
      chk($sformatf("vec%0d_rf_bus", i), ex_to_rf_bus, exp_rf(vecs[i]));
      chk($sformatf("vec%0d_sram", i), sram_now(), exp_sram(vecs[i]));
      $display("vec%0d: result=%h rf_bus=%h addr=%h", i, ex_to_mem_bus[31:0], ex_to_rf_bus, data_sram_addr);
    end

    // Multiply, signed and unsigned
    id_bus = hilo_inst(6'h18, 1'b0, 32'h80000000, 32'h00000002);
    tick();
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    tick();
    chk("mult_hi", ex_to_rf_bus, {1'b1, 5'd3, 32'hFFFFFFFF});
    id_bus = hilo_inst(6'h12, 1'b1, 32'd0, 32'd0);
    tick();
    chk("mult_lo", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000000});
    $display("mult 80000000*2: lo=%h", ex_to_rf_bus[31:0]);
    id_bus = hilo_inst(6'h19, 1'b0, 32'h80000000, 32'h00000002);
    tick();
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    tick();
    chk("multu_hi", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000001});
    $display("multu 80000000*2: hi=%h", ex_to_rf_bus[31:0]);
    id_bus = hilo_inst(6'h18, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    id_bus = hilo_inst(6'h12, 1'b1, 32'd0, 32'd0);
    tick();
    chk("mult_m1_lo", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000001});
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    tick();
    chk("mult_m1_hi", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000000});
    id_bus = hilo_inst(6'h19, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    tick();
    chk("multu_max_hi", ex_to_rf_bus, {1'b1, 5'd3, 32'hFFFFFFFE});
    id_bus = hilo_inst(6'h12, 1'b1, 32'd0, 32'd0);
    tick();
    chk("multu_max_lo", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000001});
    $display("multu ffffffff^2: lo=%h", ex_to_rf_bus[31:0]);

    // Divides
    do_div("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd14, 32'd2, 2);
    do_div("div_m7_2", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    do_div("div_9_0", 6'h1A, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 0);

    // mthi/mtlo, then reset in the middle of a divide
    id_bus = hilo_inst(6'h11, 1'b0, 32'h00000055, 32'd0);
    tick();
    id_bus = hilo_inst(6'h13, 1'b0, 32'h00000066, 32'd0);
    tick();
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    tick();
    chk("mthi", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000055});
    id_bus = hilo_inst(6'h12, 1'b1, 32'd0, 32'd0);
    tick();
    chk("mtlo", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000066});
    $display("mtlo/mflo: %h", ex_to_rf_bus[31:0]);
    id_bus = hilo_inst(6'h1B, 1'b0, 32'd100, 32'd7);
    tick();
    id_bus = hilo_inst(6'h10, 1'b1, 32'd0, 32'd0);
    for (int k = 0; k < 11; k++) tick();
    chk("midreset_before_stallreq", stallreq_for_ex, 1'b1);
    rst = 1'b0;
    tick();
    chk("midreset_stallreq", stallreq_for_ex, 1'b0);
    chk("midreset_mem_bus", ex_to_mem_bus, 76'd0);
    chk("midreset_rf_bus", ex_to_rf_bus, 38'd0);
    chk("midreset_sram", sram_now(), 69'd0);
    $display("reset mid-divide: stallreq=%b", stallreq_for_ex);
    rst = 1'b1;
    tick();
    chk("midreset_hi_cleared", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000000});
    id_bus = hilo_inst(6'h12, 1'b1, 32'd0, 32'd0);
    tick();
    chk("midreset_lo_cleared", ex_to_rf_bus, {1'b1, 5'd3, 32'h00000000});
    do_div("divu_after_reset", 6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1);

    // Stall behaviour: bubble when EX stops but MEM moves, hold when both stop
    id_bus = vbus(vecs[6]);
    tick();
    chk("stall_pre_mem_bus", ex_to_mem_bus, exp_mem(vecs[6]));
    tb_stall = 6'b000100;
    id_bus = vbus(vecs[1]);
    tick();
    chk("stall_bubble_mem_bus", ex_to_mem_bus, 76'd0);
    chk("stall_bubble_rf_bus", ex_to_rf_bus, 38'd0);
    $display("stall[2] only: mem_bus=%h", ex_to_mem_bus);
    tb_stall = 6'd0;
    id_bus = vbus(vecs[6]);
    tick();
    tb_stall = 6'b001100;
    id_bus = vbus(vecs[1]);
    tick();
    chk("stall_hold1_mem_bus", ex_to_mem_bus, exp_mem(vecs[6]));
    tick();
    chk("stall_hold2_mem_bus", ex_to_mem_bus, exp_mem(vecs[6]));
    chk("stall_hold2_rf_bus", ex_to_rf_bus, exp_rf(vecs[6]));
    $display("stall[2]&stall[3]: mem_bus=%h", ex_to_mem_bus);
    tb_stall = 6'd0;
    tick();
    chk("stall_release_mem_bus", ex_to_mem_bus, exp_mem(vecs[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex.md
EX -- requirements
Module: EX

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-low reset (rst==0 at a clk edge resets the block).
REQ-003 SHALL have ports: stall  in  6  stall bus, bit=1 means Stop; EX uses stall[2] and stall[3].
REQ-004 SHALL have ports: id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], data1[63:32], data2[31:0]}.
REQ-005 SHALL have ports: ex_to_mem_bus  out  76  {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-006 SHALL have ports: ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}, forwarding path to decode.
REQ-007 SHALL have ports: data_sram_en  out  1; data_sram_wen  out  4; data_sram_addr  out  32; data_sram_wdata  out  32.
REQ-008 SHALL have ports: stallreq_for_ex  out  1  high while the divider needs EX held.

Function
REQ-009 SHALL hold an input register: rst==0 -> 0; else stall[2]==1 & stall[3]==0 -> 0 (bubble); else stall[2]==0 -> id_to_ex_bus; else hold.
REQ-010 SHALL select src1: sel_alu_src1[0] data1, [1] pc, [2] zero-extended inst[10:6]; src2: sel_alu_src2[0] data2, [1] sign-ext inst[15:0], [2] 32'd8, [3] zero-ext inst[15:0].
REQ-011 SHALL decode alu_op bits 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; shifts shift src2 by src1[4:0]; lui = {src2[15:0],16'b0}; slt signed, sltu unsigned, result 0/1; add/sub modulo 2^32.
REQ-012 SHALL treat alu_op==0 with rf_we==0 as a bubble producing all-zero outputs.
REQ-013 SHALL decode from inst (opcode 0): mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mflo 0x12, mthi 0x11, mtlo 0x13.
REQ-014 SHALL set ex_result = hi for mfhi, lo for mflo, else ALU result.
REQ-015 SHALL compute mult/multu in one cycle as a 64-bit product; {hi,lo} written at the edge where stall[2]==0; mthi/mtlo write data1 likewise.
REQ-016 SHALL implement div/divu with FSM IDLE, BUSY, DONE and a 5-bit counter.
REQ-017 IDLE: on div/divu in EX, latch |data1|, |data2| (signed) or raw (unsigned) and the sign flags, assert stallreq_for_ex, go BUSY with counter=0.
REQ-018 BUSY: one restoring shift-subtract iteration per cycle, stallreq_for_ex=1; after counter==31 go DONE (32 BUSY cycles).
REQ-019 DONE: stallreq_for_ex=0; write lo=quotient, hi=remainder at the first edge with stall[2]==0, then IDLE; otherwise stay in DONE without writing.
REQ-020 Signed fix-up: quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-021 Divide by zero: no trap, same 33-cycle latency; unsigned result lo=32'hFFFFFFFF, hi=dividend, then signed fix-up.
REQ-022 Total stallreq_for_ex high time per div: exactly 33 cycles (IDLE start cycle + 32 BUSY).
REQ-023 SHALL drive data_sram_en=data_ram_en, data_sram_wen=data_ram_wen, addr=data1+sign-ext inst[15:0], wdata=data2; all zero during bubble.
REQ-024 ex_to_rf_bus rf_we SHALL be 0 while FSM is not IDLE, and for mfhi/mflo follows the decoded rf_we.

Reset
REQ-025 rst==0 SHALL clear input register, hi, lo, counter and divider datapath, force FSM to IDLE (also mid-division), and drive stallreq_for_ex and all bus/SRAM outputs to 0 in the following cycle.

Verification
REQ-026 addiu: data1=5, imm=0xFFFF, alu_op=add, src2=sign-imm -> ex_result=4, rf_we=1 on ex_to_rf_bus next cycle.
REQ-027 divu 100/7 -> stallreq_for_ex high exactly 33 cycles; then mflo gives 14, mfhi gives 2.
REQ-028 div -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; div 9/0 -> lo=32'hFFFFFFFF, hi=9.
REQ-029 mult 0x80000000 x 2 -> hi=32'hFFFFFFFF, lo=0; multu same operands -> hi=1, lo=0.
REQ-030 rst driven low at BUSY counter=10 -> next cycle stallreq_for_ex=0, FSM IDLE, hi=lo=0.
REQ-031 stall[2]=1, stall[3]=0 -> ex_to_mem_bus all zero next cycle; stall[2]=stall[3]=1 -> outputs held unchanged.
